lock_code_entry: RTL and testbench



---
 rtl/lock_code_entry.sv | 235 +++++++++++++++++++++++
 tb/tb_lock_code_entry.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_code_entry.sv
// Purpose: debounce the coded-lock front panel and offer the assembled code to the checker.
// Latency: press accepted 2+DEBOUNCE_CYCLES edges after raw low; state update one edge later.
// Backpressure: code_valid holds with code_data stable until code_ready; panel events dropped meanwhile.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   key_n[3:0]      raw digit buttons (active-low), key_n[i] enters digit value i
//   enter_n,clear_n raw confirm / cancel buttons (active-low)
//   code_data       assembled code, first digit in the MS 2 bits
//   code_valid      code offered to checker; code_ready accepts it
//   digit_cnt       digits currently held
//   entry_err       one-cycle pulse: enter with an incomplete code
//   timeout_pulse   one-cycle pulse on auto-clear
// Build option: define ENTRY_TIMEOUT_EN to auto-clear a stalled entry after
// TIMEOUT_CYCLES idle cycles; otherwise timeout_pulse is tied low.
module lock_code_entry #(
  parameter int DIGITS          = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   key_n,
  input  logic                         enter_n,
  input  logic                         clear_n,
  output logic [2*DIGITS-1:0]          code_data,
  output logic                         code_valid,
  input  logic                         code_ready,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic                         entry_err,
  output logic                         timeout_pulse
);

  localparam int CW   = 2 * DIGITS;
  localparam int CNTW = $clog2(DIGITS + 1);
  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DIGITS);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0]  DB_ONE   = DBW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    SEND  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: bit order {clear, enter, key3..key0}
  // ---------------------------------------------------------------------------
  logic [5:0]     raw_n;
  logic [5:0]     sync1_n;
  logic [5:0]     sync2_n;
  logic [5:0]     stable_n;   // debounced level, 1 = released
  logic [5:0]     press_vld;  // one-cycle press strobes
  logic [DBW-1:0] db_cnt [6];

  assign raw_n = {clear_n, enter_n, key_n};

  // The counter tracks how many consecutive samples disagree with the
  // debounced level; the level flips on the DEBOUNCE_CYCLES-th disagreement.
  // Only a high-to-low flip produces a strobe, so a held button fires once
  // and must be seen released before it can fire again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_n   <= '1;
      sync2_n   <= '1;
      stable_n  <= '1;
      press_vld <= '0;
      for (int b = 0; b < 6; b++) db_cnt[b] <= '0;
    end else begin
      sync1_n <= raw_n;
      sync2_n <= sync1_n;
      for (int b = 0; b < 6; b++) begin
        press_vld[b] <= 1'b0;
        if (sync2_n[b] != stable_n[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            stable_n[b]  <= sync2_n[b];
            db_cnt[b]    <= '0;
            press_vld[b] <= ~sync2_n[b];
          end else begin
            db_cnt[b] <= db_cnt[b] + DB_ONE;
          end
        end else begin
          db_cnt[b] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event decode: clear beats enter beats the lowest-index digit
  // ---------------------------------------------------------------------------
  logic          clr_evt;
  logic          ent_evt;
  logic          dig_evt;
  logic          any_evt;
  logic [1:0]    dig_val;
  logic [CW-1:0] shifted;

  assign clr_evt = press_vld[5];
  assign ent_evt = press_vld[4];
  assign dig_evt = |press_vld[3:0];
  assign any_evt = |press_vld;

  always_comb begin
    dig_val = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (press_vld[i]) dig_val = 2'(i);
    end
  end

  // Written as shift-then-insert so DIGITS=1 needs no negative slice.
  always_comb begin
    shifted      = code_data << 2;
    shifted[1:0] = dig_val;
  end

  // ---------------------------------------------------------------------------
  // Entry FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t state;

`ifdef ENTRY_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [TOW-1:0] TO_ONE  = TOW'(1);

  logic [TOW-1:0] idle_cnt;
  logic           to_pulse;

  assign timeout_pulse = to_pulse;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_pulse  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code_data  <= '0;
      code_valid <= 1'b0;
      digit_cnt  <= '0;
      entry_err  <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      idle_cnt   <= '0;
      to_pulse   <= 1'b0;
`endif
    end else begin
      entry_err <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      to_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef ENTRY_TIMEOUT_EN
          idle_cnt <= '0;
`endif
          if (clr_evt) begin
            // nothing held, nothing to clear
          end else if (ent_evt) begin
            entry_err <= 1'b1;
          end else if (dig_evt) begin
            code_data <= shifted;
            digit_cnt <= CNT_ONE;
            state     <= ENTRY;
          end
        end

        ENTRY: begin
`ifdef ENTRY_TIMEOUT_EN
          // Any event restarts the idle count, even one that is ignored,
          // and wins over a simultaneous expiry.
          idle_cnt <= '0;
`endif
          if (clr_evt) begin
            code_data <= '0;
            digit_cnt <= '0;
            state     <= IDLE;
          end else if (ent_evt) begin
            if (digit_cnt == CNT_FULL) begin
              code_valid <= 1'b1;
              state      <= SEND;
            end else begin
              entry_err <= 1'b1;
              code_data <= '0;
              digit_cnt <= '0;
              state     <= IDLE;
            end
          end else if (dig_evt) begin
            if (digit_cnt != CNT_FULL) begin
              code_data <= shifted;
              digit_cnt <= digit_cnt + CNT_ONE;
            end
          end
`ifdef ENTRY_TIMEOUT_EN
          else if (idle_cnt == TO_LAST) begin
            to_pulse  <= 1'b1;
            code_data <= '0;
            digit_cnt <= '0;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + TO_ONE;
          end
`endif
        end

        SEND: begin
          // Panel events are discarded here; the offer is never withdrawn.
          if (code_ready) begin
            code_valid <= 1'b0;
            code_data  <= '0;
            digit_cnt  <= '0;
            state      <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          code_data  <= '0;
          code_valid <= 1'b0;
          digit_cnt  <= '0;
        end
      endcase
    end
  end

  // Keeps the event-decode signals referenced in every build configuration.
  logic unused_evt;
  assign unused_evt = any_evt;

endmodule

// File: tb/tb_lock_code_entry.sv
module tb_lock_code_entry;

  localparam int DIGITS = 2;
  localparam int DB     = 4;
  localparam int TO     = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic       enter_n = 1'b1;
  logic       clear_n = 1'b1;
  logic       code_ready = 1'b0;
  logic [3:0] code_data;
  logic       code_valid;
  logic [1:0] digit_cnt;
  logic       entry_err;
  logic       timeout_pulse;

  int n_pass  = 0;
  int n_total = 0;

  // Scoreboard: codes expected to be handed to the checker, in order.
  logic [3:0] exp_q[$];
  logic [3:0] exp_c;

  always #5 clk = ~clk;

  lock_code_entry #(
    .DIGITS         (DIGITS),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .enter_n      (enter_n),
    .clear_n      (clear_n),
    .code_data    (code_data),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .digit_cnt    (digit_cnt),
    .entry_err    (entry_err),
    .timeout_pulse(timeout_pulse)
  );

  // Handshake monitor: pops the scoreboard on each accepted code.
  always @(negedge clk) begin
    if (!rst && code_valid && code_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL hs_unexpected: got code %b, want no handshake", code_data);
      end else begin
        exp_c = exp_q.pop_front();
        if (code_data !== exp_c) $display("FAIL hs_code: got %b want %b", code_data, exp_c);
        else n_pass++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit, want $finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all operate 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    if (idx < 4) key_n[idx] = v;
    else if (idx == 4) enter_n = v;
    else clear_n = v;
  endtask

  // idx 0..3 digit, 4 enter, 5 clear
  task automatic press(input int idx);
    set_btn(idx, 1'b0);
    tick(8);
    set_btn(idx, 1'b1);
    tick(8);
  endtask

  task automatic press_watch(input int idx, output int err_pulses, output int valid_seen);
    err_pulses = 0;
    valid_seen = 0;
    set_btn(idx, 1'b0);
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (entry_err === 1'b1) err_pulses++;
      if (code_valid === 1'b1) valid_seen++;
      if (k == 7) set_btn(idx, 1'b1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    n_total++; if (code_data !== 4'b0000) $display("FAIL rst_data: got %b want 0000", code_data); else n_pass++;
    n_total++; if (code_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", code_valid); else n_pass++;
    n_total++; if (digit_cnt !== 2'd0) $display("FAIL rst_cnt: got %0d want 0", digit_cnt); else n_pass++;
    n_total++; if (entry_err !== 1'b0) $display("FAIL rst_err: got %b want 0", entry_err); else n_pass++;
    n_total++; if (timeout_pulse !== 1'b0) $display("FAIL rst_to: got %b want 0", timeout_pulse); else n_pass++;
  endtask

  task automatic test_code_send();
    int good;
    press(2);
    press(3);
    n_total++; if (digit_cnt !== 2'd2) $display("FAIL send_cnt: got %0d want 2", digit_cnt); else n_pass++;
    n_total++; if (code_data !== 4'b1011) $display("FAIL send_data: got %b want 1011", code_data); else n_pass++;
    exp_q.push_back(4'b1011);
    press(4);
    good = 0;
    for (int k = 0; k < 10; k++) begin
      if (code_valid === 1'b1 && code_data === 4'b1011) good++;
      tick(1);
    end
    n_total++; if (good !== 10) $display("FAIL send_hold: got %0d stable cycles want 10", good); else n_pass++;
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    n_total++; if (code_valid !== 1'b0) $display("FAIL send_drop: got %b want 0", code_valid); else n_pass++;
    n_total++; if (digit_cnt !== 2'd0) $display("FAIL send_cnt0: got %0d want 0", digit_cnt); else n_pass++;
    n_total++; if (code_data !== 4'b0000) $display("FAIL send_data0: got %b want 0000", code_data); else n_pass++;
  endtask

  task automatic test_debounce();
    int max_cnt;
    // glitch shorter than the debounce window
    key_n[1] = 1'b0;
    tick(3);
    key_n[1] = 1'b1;
    tick(15);
    n_total++; if (digit_cnt !== 2'd0) $display("FAIL db_glitch: got %0d want 0", digit_cnt); else n_pass++;
    // long hold: one event, applied at edge 2+DB+1
    key_n[1] = 1'b0;
    tick(6);
    n_total++; if (digit_cnt !== 2'd0) $display("FAIL db_early: got %0d want 0 at edge 6", digit_cnt); else n_pass++;
    tick(1);
    n_total++; if (digit_cnt !== 2'd1) $display("FAIL db_latency: got %0d want 1 at edge 7", digit_cnt); else n_pass++;
    max_cnt = 0;
    for (int k = 0; k < 43; k++) begin
      tick(1);
      if (int'(digit_cnt) > max_cnt) max_cnt = int'(digit_cnt);
    end
    key_n[1] = 1'b1;
    tick(10);
    n_total++; if (max_cnt !== 1) $display("FAIL db_hold: got max cnt %0d want 1", max_cnt); else n_pass++;
    press(5);
  endtask

  task automatic test_entry_err();
    int errs, vseen;
    press_watch(4, errs, vseen);
    n_total++; if (errs !== 1) $display("FAIL err_idle: got %0d pulses want 1", errs); else n_pass++;
    press(1);
    n_total++; if (digit_cnt !== 2'd1) $display("FAIL err_cnt1: got %0d want 1", digit_cnt); else n_pass++;
    press_watch(4, errs, vseen);
    n_total++; if (errs !== 1) $display("FAIL err_pulse: got %0d pulses want 1", errs); else n_pass++;
    n_total++; if (vseen !== 0) $display("FAIL err_valid: got %0d valid cycles want 0", vseen); else n_pass++;
    n_total++; if (digit_cnt !== 2'd0) $display("FAIL err_cnt0: got %0d want 0", digit_cnt); else n_pass++;
    n_total++; if (code_data !== 4'b0000) $display("FAIL err_data: got %b want 0000", code_data); else n_pass++;
  endtask

  task automatic test_overflow();
    press(0);
    press(1);
    press(2);
    n_total++; if (code_data !== 4'b0001) $display("FAIL ovf_data: got %b want 0001", code_data); else n_pass++;
    n_total++; if (digit_cnt !== 2'd2) $display("FAIL ovf_cnt: got %0d want 2", digit_cnt); else n_pass++;
    press(5);
    n_total++; if (code_data !== 4'b0000) $display("FAIL clr_data: got %b want 0000", code_data); else n_pass++;
    n_total++; if (digit_cnt !== 2'd0) $display("FAIL clr_cnt: got %0d want 0", digit_cnt); else n_pass++;
  endtask

  task automatic test_send_lock();
    press(3);
    press(3);
    exp_q.push_back(4'b1111);
    press(4);
    press(5);
    press(0);
    press(2);
    n_total++; if (code_data !== 4'b1111) $display("FAIL lock_data: got %b want 1111", code_data); else n_pass++;
    n_total++; if (code_valid !== 1'b1) $display("FAIL lock_valid: got %b want 1", code_valid); else n_pass++;
    n_total++; if (digit_cnt !== 2'd2) $display("FAIL lock_cnt: got %0d want 2", digit_cnt); else n_pass++;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    n_total++; if (code_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", code_valid); else n_pass++;
    n_total++; if (code_data !== 4'b0000) $display("FAIL abort_data: got %b want 0000", code_data); else n_pass++;
    n_total++; if (digit_cnt !== 2'd0) $display("FAIL abort_cnt: got %0d want 0", digit_cnt); else n_pass++;
    n_total++; if (entry_err !== 1'b0 || timeout_pulse !== 1'b0) $display("FAIL abort_pulses: got err=%b to=%b want 0/0", entry_err, timeout_pulse); else n_pass++;
    tick(4);
  endtask

  task automatic test_back_to_back();
    // ready held high throughout: ignored until SEND, then accepts at once
    code_ready = 1'b1;
    press(0);
    press(2);
    n_total++; if (digit_cnt !== 2'd2) $display("FAIL b2b_cnt: got %0d want 2", digit_cnt); else n_pass++;
    exp_q.push_back(4'b0010);
    press(4);
    exp_q.push_back(4'b1100);
    press(3);
    press(0);
    press(4);
    n_total++; if (code_valid !== 1'b0) $display("FAIL b2b_valid: got %b want 0", code_valid); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size()); else n_pass++;
    code_ready = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef ENTRY_TIMEOUT_EN
    int first, pulses;
    key_n[1] = 1'b0;
    tick(7);
    key_n[1] = 1'b1;
    n_total++; if (digit_cnt !== 2'd1) $display("FAIL to_start: got %0d want 1", digit_cnt); else n_pass++;
    first = -1;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (timeout_pulse === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    n_total++; if (first !== TO) $display("FAIL to_delay: got %0d cycles want %0d", first, TO); else n_pass++;
    n_total++; if (pulses !== 1) $display("FAIL to_pulses: got %0d want 1", pulses); else n_pass++;
    n_total++; if (digit_cnt !== 2'd0) $display("FAIL to_cnt: got %0d want 0", digit_cnt); else n_pass++;
`else
    int pulses;
    press(1);
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (timeout_pulse !== 1'b0) pulses++;
    end
    n_total++; if (digit_cnt !== 2'd1) $display("FAIL noto_cnt: got %0d want 1", digit_cnt); else n_pass++;
    n_total++; if (pulses !== 0) $display("FAIL noto_pulse: got %0d want 0", pulses); else n_pass++;
    press(5);
    n_total++; if (digit_cnt !== 2'd0) $display("FAIL noto_clr: got %0d want 0", digit_cnt); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_code_send();
    test_debounce();
    test_entry_err();
    test_overflow();
    test_send_lock();
    test_back_to_back();
    test_timeout();
    tick(4);
    n_total++; if (exp_q.size() !== 0) $display("FAIL sb_empty: got %0d pending want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
